// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
// The optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width. WIDTH is at least 2, so $clog2 never yields zero.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit combinational full adder.
// This is the single adder cell that the serial sequencer time-shares.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: it pushes one bit pair per clock, LSB first, through a single fa_cell.
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output state_e           state_o
);

    localparam int              CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] sum_sr_d;

    fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign sum_sr_d = {cell_s, sum_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            // Status flags trail the state by one edge, so every output is a plain flop.
            busy_q <= (state_q == RUN);
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    sum_sr_q <= sum_sr_d;
                    c_q      <= cell_co;
                    if (cnt_q == LAST) begin
                        sum_q   <= sum_sr_d;
                        cout_q  <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
                        // c_q holds the carry into the MSB while the MSB is being added.
                        ovf_q   <= c_q ^ cell_co;
`endif
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf     = ovf_q;
`endif
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases, then random operations scored against an arithmetic model.
// Build with SERIAL_ADD_OVF_EN defined to include the ovf checks.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W        = 8;
    localparam int MAX_WAIT = W + 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    state_e       state_o;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    logic         ovf_exp_q[$];
    logic         held_ovf;
`endif

    logic [W:0] exp_q[$];
    logic [W:0] held;
    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf     (ovf),
`endif
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // Runs one operation. With poke set, start is re-pulsed during RUN and DONE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input bit poke);
        logic [W:0] exp;
        int lat;
        int busy_n;
        int dones;
        lat = 0;
        busy_n = 0;
        dones = 0;
        a = ta;
        b = tbv;
        cin = tc;
        start = 1'b1;
        exp_q.push_back(ref_add(ta, tbv, tc));
`ifdef SERIAL_ADD_OVF_EN
        ovf_exp_q.push_back(ref_ovf(ta, tbv, tc));
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        check("hold_after_start", {cout, sum}, held);
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (lat == 0) lat = k;
            end
            if (k == W - 1) check("hold_during_run", {cout, sum}, held);
            if (poke && (k == 3 || k == W)) begin
                start = 1'b1;
                a = 8'h33;
            end else begin
                start = 1'b0;
            end
            if (!poke && lat != 0) break;
        end
        check("latency", lat, W + 1);
        check("busy_cycles", busy_n, W);
        if (poke) check("done_count", dones, 1);
        exp = exp_q.pop_front();
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        held = exp;
`ifdef SERIAL_ADD_OVF_EN
        held_ovf = ovf_exp_q.pop_front();
        check("ovf", ovf, held_ovf);
`endif
    endtask

    // Starts an operation and hits rst after rst_at RUN edges; no done may follow.
    task automatic do_abort(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int rst_at);
        int dones;
        int busy_n;
        dones = 0;
        busy_n = 0;
        a = ta;
        b = tbv;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < rst_at; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", state_o, IDLE);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("abort_ovf", ovf, 0);
        held_ovf = 1'b0;
`endif
        held = '0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
            if (busy) busy_n++;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_busy", busy_n, 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        held = '0;
`ifdef SERIAL_ADD_OVF_EN
        held_ovf = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", state_o, IDLE);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'hAA, 8'h55, 1'b1, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, 1'b0);
        do_op(8'h3C, 8'h0A, 1'b1, 1'b1);

        do_abort(8'hC3, 8'h5A, 4);
        do_op(8'h01, 8'h02, 1'b0, 1'b0);

        // rst wins over start in the same IDLE cycle.
        rst = 1'b1;
        start = 1'b1;
        a = 8'h44;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        held = '0;
`ifdef SERIAL_ADD_OVF_EN
        held_ovf = 1'b0;
`endif
        check("rst_start_state", state_o, IDLE);
        check("rst_start_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_start_state2", state_o, IDLE);
        check("rst_start_busy2", busy, 0);
        check("rst_start_sum", sum, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(pick_operand(), pick_operand(), 1'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
